// File: rtl/ahb_fifo_write.sv
// ahb_fifo_write: JTAG data register that deframes serial TDI into FIFO writes (optional error flags via AHB_FIFO_WRITE_ERR_EN)
module ahb_fifo_write #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  TCK,
  input  logic                  tlr_reset,
  input  logic                  TDI,
  input  logic                  dr_shift,
  input  logic                  ahb_fifo_write_select,
  input  logic                  wfull,
  input  logic                  err_clear,
  output logic                  winc,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  frame_err,
  output logic                  overflow
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] STOP = 2'd2;
  logic [1:0] state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DATA_WIDTH-1:0] sr;
  logic shift, last, stop_edge, accept;
  assign shift = dr_shift & ahb_fifo_write_select;
  assign last = cnt == CW'(DATA_WIDTH - 1);
  assign stop_edge = shift && state == STOP;
  assign accept = stop_edge & ~TDI & ~wfull;
  // next state and bit counter; everything holds while shift is low
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (shift) begin
      state_n = state == IDLE ? (TDI ? DATA : IDLE) : state == DATA ? (last ? STOP : DATA) : IDLE;
      cnt_n = state == IDLE ? '0 : state == DATA ? cnt + 1'b1 : cnt;
    end
  end
  // frame sequencing and the registered one-cycle FIFO write
  always_ff @(posedge TCK) begin
    if (tlr_reset) begin
      state <= IDLE;
      cnt <= '0;
      winc <= 1'b0;
      wdata <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      winc <= accept;
      if (accept) wdata <= sr;
    end
  end
  // data bits land at the position given by the counter, LSB first
  always_ff @(posedge TCK) begin
    if (tlr_reset) sr <= '0;
    else if (shift && state == DATA)
      for (int i = 0; i < DATA_WIDTH; i++)
        if (cnt == CW'(i)) sr[i] <= TDI;
  end
`ifdef AHB_FIFO_WRITE_ERR_EN
  logic drop_full, bad_stop;
  assign drop_full = stop_edge & ~TDI & wfull;
  assign bad_stop = stop_edge & TDI;
  // sticky error flags; a new error on the clearing edge wins
  always_ff @(posedge TCK) begin
    if (tlr_reset) begin
      frame_err <= 1'b0;
      overflow <= 1'b0;
    end else begin
      frame_err <= bad_stop | (frame_err & ~err_clear);
      overflow <= drop_full | (overflow & ~err_clear);
    end
  end
`else
  logic unused_err_clear;
  assign unused_err_clear = err_clear;
  assign frame_err = 1'b0;
  assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_ahb_fifo_write.sv
// tb_ahb_fifo_write: table-driven and randomized frame-level checks of ahb_fifo_write
module tb_ahb_fifo_write;
`ifdef AHB_FIFO_WRITE_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  logic TCK = 1'b0;
  logic tlr_reset = 1'b0, TDI = 1'b0, dr_shift = 1'b0, sel = 1'b0, wfull = 1'b0, err_clear = 1'b0;
  logic winc, frame_err, overflow;
  logic [7:0] wdata;
  int tests = 0, fails = 0, pulses = 0;
  logic prev_winc = 1'b0;

  always #5 TCK = ~TCK;

  ahb_fifo_write #(.DATA_WIDTH(8)) dut (
    .TCK(TCK), .tlr_reset(tlr_reset), .TDI(TDI), .dr_shift(dr_shift),
    .ahb_fifo_write_select(sel), .wfull(wfull), .err_clear(err_clear),
    .winc(winc), .wdata(wdata), .frame_err(frame_err), .overflow(overflow)
  );

  always @(negedge TCK) begin
    if (winc === 1'b1) begin
      tests++;
      pulses++;
      if (prev_winc) begin
        fails++;
        $display("FAIL winc_width act=2+ cycles exp=1 cycle");
      end
    end
    prev_winc = (winc === 1'b1);
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h", n, act, exp);
    end
  endtask

  task automatic edge_(input bit r, input bit dr, input bit s, input bit d, input bit wf, input bit clr);
    tlr_reset = r; dr_shift = dr; sel = s; TDI = d; wfull = wf; err_clear = clr;
    @(posedge TCK);
    #1;
    tlr_reset = 1'b0; dr_shift = 1'b0; err_clear = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) edge_(0, 0, 1, 1'($urandom), 1'($urandom), 0);
  endtask

  task automatic send(input logic [7:0] d, input bit stop, input bit wf, input int pause_at, input bit clr_stop);
    edge_(0, 1, 1, 1, 1'($urandom), 0);
    for (int i = 0; i < 8; i++) begin
      if (i == pause_at)
        for (int k = 0; k < 4; k++) edge_(0, k[0], ~k[0], 1'($urandom), 1'($urandom), 0);
      edge_(0, 1, 1, d[i], 1'($urandom), 0);
    end
    edge_(0, 1, 1, stop, wf, clr_stop);
  endtask

  typedef struct {
    int lead; bit clr; logic [7:0] d; bit stop; bit wf; int pause_at;
    int np; logic [7:0] wd; bit fe; bit ov;
  } row_t;
  row_t rows[6];

  initial begin
    int p0, np;
    bit mfe, mov, stop, wf;
    logic [7:0] d, exp_wd;
    rows[0] = '{0, 0, 8'hA5, 0, 0, -1, 1, 8'hA5, 0, 0};
    rows[1] = '{5, 0, 8'h3C, 0, 0,  3, 1, 8'h3C, 0, 0};
    rows[2] = '{0, 0, 8'hFF, 0, 1, -1, 0, 8'h3C, 0, 1};
    rows[3] = '{0, 1, 8'h12, 1, 0, -1, 0, 8'h3C, 1, 0};
    rows[4] = '{3, 0, 8'h81, 0, 0,  5, 1, 8'h81, 1, 0};
    rows[5] = '{0, 1, 8'h00, 0, 0, -1, 1, 8'h00, 0, 0};

    edge_(1, 1, 1, 1, 1, 1);
    edge_(1, 0, 0, 0, 0, 0);
    chk("rst_winc", winc, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overflow", overflow, 0);

    foreach (rows[r]) begin
      p0 = pulses;
      repeat (rows[r].lead) edge_(0, 1, 1, 0, 1'($urandom), 0);
      if (rows[r].clr) edge_(0, 0, 1, 0, 0, 1);
      send(rows[r].d, rows[r].stop, rows[r].wf, rows[r].pause_at, 0);
      idle(1);
      chk($sformatf("row%0d_pulses", r), pulses - p0, rows[r].np);
      chk($sformatf("row%0d_wdata", r), wdata, rows[r].wd);
      chk($sformatf("row%0d_frame_err", r), frame_err, rows[r].fe & ERR);
      chk($sformatf("row%0d_overflow", r), overflow, rows[r].ov & ERR);
    end

    p0 = pulses;
    edge_(0, 1, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) edge_(0, 1, 1, 1'(i), 0, 0);
    edge_(1, 1, 1, 1, 0, 0);
    send(8'h81, 0, 0, -1, 0);
    idle(1);
    chk("midreset_pulses", pulses - p0, 1);
    chk("midreset_wdata", wdata, 8'h81);
    chk("midreset_frame_err", frame_err, 0);

    p0 = pulses;
    edge_(0, 1, 1, 1, 0, 0);
    for (int i = 0; i < 8; i++) edge_(0, 1, 1, 1'(i), 0, 0);
    edge_(1, 1, 1, 0, 0, 0);
    idle(1);
    chk("stopreset_pulses", pulses - p0, 0);
    chk("stopreset_wdata", wdata, 0);

    send(8'h01, 0, 0, -1, 0);
    chk("b2b_first_winc", winc, 1);
    chk("b2b_first_wdata", wdata, 8'h01);
    send(8'h80, 0, 0, -1, 0);
    chk("b2b_second_winc", winc, 1);
    chk("b2b_second_wdata", wdata, 8'h80);
    idle(1);
    chk("b2b_winc_low", winc, 0);

    send(8'h12, 1, 0, -1, 1);
    idle(1);
    chk("setwins_frame_err", frame_err, ERR);
    send(8'h34, 0, 1, -1, 1);
    idle(1);
    chk("setwins_overflow", overflow, ERR);
    chk("clear_frame_err", frame_err, 0);
    edge_(0, 0, 0, 0, 0, 1);
    chk("clear_overflow", overflow, 0);

    edge_(1, 0, 0, 0, 0, 0);
    mfe = 0; mov = 0; exp_wd = 0;
    for (int f = 0; f < 40; f++) begin
      p0 = pulses;
      repeat ($urandom_range(3, 0)) edge_(0, 1, 1, 0, 1'($urandom), 0);
      idle($urandom_range(1, 0));
      if ($urandom_range(5, 0) == 0) begin
        edge_(0, 0, 1, 0, 0, 1);
        mfe = 0; mov = 0;
      end
      d = 8'($urandom);
      stop = ($urandom_range(5, 0) == 0);
      wf = ($urandom_range(3, 0) == 0);
      send(d, stop, wf, $urandom_range(10, 0), 0);
      np = 0;
      if (stop) mfe = 1;
      else if (wf) mov = 1;
      else begin np = 1; exp_wd = d; end
      idle(1);
      chk($sformatf("rnd%0d_pulses", f), pulses - p0, np);
      chk($sformatf("rnd%0d_wdata", f), wdata, exp_wd);
      chk($sformatf("rnd%0d_frame_err", f), frame_err, mfe & ERR);
      chk($sformatf("rnd%0d_overflow", f), overflow, mov & ERR);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
